// File: rtl/axi_selftest_mem_system_if.sv
// Internal AXI4-Lite bus of the self-test subsystem. PROT is always 0 in this
// subsystem, so it is not carried on the bus.
interface axi_selftest_mem_system_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bvalid, arready, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport monitor (
    input bvalid, bready, bresp, rvalid, rready, rdata, rresp
  );
endinterface

// File: rtl/axi_selftest_mem_system.sv
// AXI4-Lite self-test: pattern master, passive scoreboard and word memory on one bus.
// Optional macro SELFTEST_ERR_INJECT_EN adds inject_err to corrupt write data of txn 0.

module axi_selftest_mem_master #(
  parameter int          ADDR_W    = 12,
  parameter int          NUM_TXN   = 16,
  parameter int          BASE_ADDR = 0,
  parameter logic [31:0] SEED      = 32'hDEAD_BEEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
`ifdef SELFTEST_ERR_INJECT_EN
  input  logic i_inject_err,
`endif
  output logic o_busy,
  output logic o_done,
  output logic o_clear,
  output logic o_fin,
  axi_selftest_mem_system_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_WR, S_WRESP, S_RD, S_RRESP, S_FIN} state_t;

  state_t     r_state, w_next;
  logic [7:0] r_idx;
  logic       r_aw_done, r_w_done, r_done;
  logic       w_last, w_aw_ok, w_w_ok, w_flip;

  assign w_last  = (r_idx == 8'(NUM_TXN - 1));
  assign w_aw_ok = r_aw_done | (bus.awvalid & bus.awready);
  assign w_w_ok  = r_w_done  | (bus.wvalid  & bus.wready);

`ifdef SELFTEST_ERR_INJECT_EN
  logic r_inject;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_inject <= 1'b0;
    else if (o_clear) r_inject <= i_inject_err;
  end
  assign w_flip = r_inject & (r_idx == 8'd0);
`else
  assign w_flip = 1'b0;
`endif

  // Address and data are pure functions of the index, so they stay stable while VALID waits.
  assign bus.awaddr = ADDR_W'(BASE_ADDR) + ADDR_W'({r_idx, 2'b00});
  assign bus.araddr = bus.awaddr;
  assign bus.wdata  = SEED ^ {4{r_idx}} ^ {31'd0, w_flip};
  assign bus.wstrb  = 4'hF;

  assign o_clear = (r_state == S_IDLE) & i_start;
  assign o_fin   = (r_state == S_FIN);
  assign o_busy  = (r_state != S_IDLE);
  assign o_done  = r_done;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next      = r_state;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    unique case (r_state)
      S_IDLE:  if (i_start) w_next = S_WR;
      S_WR: begin
        bus.awvalid = ~r_aw_done;
        bus.wvalid  = ~r_w_done;
        if (w_aw_ok && w_w_ok) w_next = S_WRESP;
      end
      S_WRESP: begin
        bus.bready = 1'b1;
        if (bus.bvalid) w_next = w_last ? S_RD : S_WR;
      end
      S_RD: begin
        bus.arvalid = 1'b1;
        if (bus.arready) w_next = S_RRESP;
      end
      S_RRESP: begin
        bus.rready = 1'b1;
        if (bus.rvalid) w_next = w_last ? S_FIN : S_RD;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= 8'd0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (o_clear) begin
        r_idx  <= 8'd0;
        r_done <= 1'b0;
      end
      if (o_fin) r_done <= 1'b1;
      if (r_state == S_WR) begin
        r_aw_done <= (w_next == S_WRESP) ? 1'b0 : w_aw_ok;
        r_w_done  <= (w_next == S_WRESP) ? 1'b0 : w_w_ok;
      end
      if ((r_state == S_WRESP && bus.bvalid) || (r_state == S_RRESP && bus.rvalid))
        r_idx <= w_last ? 8'd0 : r_idx + 8'd1;
    end
  end
endmodule

module axi_selftest_mem_slave #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 256
) (
  input  logic clk,
  input  logic rst_n,
  axi_selftest_mem_system_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [DATA_W-1:0] r_mem [MEM_WORDS];
  logic              r_bvalid, r_rvalid;
  logic [1:0]        r_bresp, r_rresp;
  logic [DATA_W-1:0] r_rdata;
  logic              w_wr_hs, w_rd_hs, w_wr_ok, w_rd_ok, w_unused;

  assign w_wr_hs  = bus.awvalid & bus.wvalid & ~r_bvalid;
  assign w_rd_hs  = bus.arvalid & ~r_rvalid;
  assign w_wr_ok  = int'(bus.awaddr[ADDR_W-1:2]) < MEM_WORDS;
  assign w_rd_ok  = int'(bus.araddr[ADDR_W-1:2]) < MEM_WORDS;
  assign w_unused = &{1'b0, bus.awaddr[1:0], bus.araddr[1:0]};

  assign bus.awready = w_wr_hs;
  assign bus.wready  = w_wr_hs;
  assign bus.arready = ~r_rvalid;
  assign bus.bvalid  = r_bvalid;
  assign bus.bresp   = r_bresp;
  assign bus.rvalid  = r_rvalid;
  assign bus.rresp   = r_rresp;
  assign bus.rdata   = r_rdata;

  // NOTE: the storage array has no reset so it maps onto plain RAM; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_wr_hs && w_wr_ok)
      for (int b = 0; b < DATA_W/8; b++)
        if (bus.wstrb[b]) r_mem[bus.awaddr[IDX_W+1:2]][8*b +: 8] <= bus.wdata[8*b +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bvalid <= 1'b0;
      r_bresp  <= 2'b00;
      r_rvalid <= 1'b0;
      r_rresp  <= 2'b00;
      r_rdata  <= '0;
    end else begin
      if (w_wr_hs) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_ok ? 2'b00 : 2'b10;
      end else if (bus.bready) begin
        r_bvalid <= 1'b0;
      end
      if (w_rd_hs) begin
        r_rvalid <= 1'b1;
        r_rresp  <= w_rd_ok ? 2'b00 : 2'b10;
        r_rdata  <= w_rd_ok ? r_mem[bus.araddr[IDX_W+1:2]] : '0;
      end else if (bus.rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end
endmodule

module axi_selftest_mem_monitor #(
  parameter logic [31:0] SEED = 32'hDEAD_BEEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic       i_fin,
  output logic [7:0] o_wr_count,
  output logic [7:0] o_rd_count,
  output logic [7:0] o_err_count,
  output logic       o_pass,
  axi_selftest_mem_system_if.monitor bus
);
  logic       w_b_hs, w_r_hs, w_b_err, w_r_err, r_slverr;
  logic [8:0] w_err_sum;

  assign w_b_hs  = bus.bvalid & bus.bready;
  assign w_r_hs  = bus.rvalid & bus.rready;
  assign w_b_err = w_b_hs & (bus.bresp != 2'b00);
  // The read count before increment is the index of the read being returned.
  assign w_r_err = w_r_hs & ((bus.rresp != 2'b00) || (bus.rdata != (SEED ^ {4{o_rd_count}})));
  assign w_err_sum = {1'b0, o_err_count} + 9'(w_b_err) + 9'(w_r_err);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_wr_count  <= 8'd0;
      o_rd_count  <= 8'd0;
      o_err_count <= 8'd0;
      o_pass      <= 1'b0;
      r_slverr    <= 1'b0;
    end else if (i_clear) begin
      o_wr_count  <= 8'd0;
      o_rd_count  <= 8'd0;
      o_err_count <= 8'd0;
      o_pass      <= 1'b0;
      r_slverr    <= 1'b0;
    end else begin
      if (w_b_hs) o_wr_count <= o_wr_count + 8'd1;
      if (w_r_hs) o_rd_count <= o_rd_count + 8'd1;
      o_err_count <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
      if ((w_b_hs && bus.bresp != 2'b00) || (w_r_hs && bus.rresp != 2'b00)) r_slverr <= 1'b1;
      if (i_fin) o_pass <= (o_err_count == 8'd0) && !r_slverr;
    end
  end
endmodule

module axi_selftest_mem_system #(
  parameter int          ADDR_W    = 12,
  parameter int          DATA_W    = 32,
  parameter int          MEM_WORDS = 256,
  parameter int          NUM_TXN   = 16,
  parameter int          BASE_ADDR = 0,
  parameter logic [31:0] SEED      = 32'hDEAD_BEEF
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       start,
`ifdef SELFTEST_ERR_INJECT_EN
  input  logic       inject_err,
`endif
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] wr_count,
  output logic [7:0] rd_count,
  output logic [7:0] err_count
);
  axi_selftest_mem_system_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) w_bus ();
  logic w_clear, w_fin;

  axi_selftest_mem_master #(
    .ADDR_W(ADDR_W), .NUM_TXN(NUM_TXN), .BASE_ADDR(BASE_ADDR), .SEED(SEED)
  ) u_master (
    .clk(aclk), .rst_n(aresetn), .i_start(start),
`ifdef SELFTEST_ERR_INJECT_EN
    .i_inject_err(inject_err),
`endif
    .o_busy(busy), .o_done(done), .o_clear(w_clear), .o_fin(w_fin), .bus(w_bus.master)
  );

  axi_selftest_mem_slave #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS)
  ) u_slave (
    .clk(aclk), .rst_n(aresetn), .bus(w_bus.slave)
  );

  axi_selftest_mem_monitor #(.SEED(SEED)) u_monitor (
    .clk(aclk), .rst_n(aresetn), .i_clear(w_clear), .i_fin(w_fin),
    .o_wr_count(wr_count), .o_rd_count(rd_count), .o_err_count(err_count),
    .o_pass(pass), .bus(w_bus.monitor)
  );
endmodule

// File: tb/tb_axi_selftest_mem_system.sv
// Self-checking bench: default-parameter instance plus an out-of-range instance,
// checked against an arithmetic model of the pattern and error rules.
module tb_axi_selftest_mem_system;
  localparam int MEM_WORDS = 256;

  logic       clk = 1'b0;
  logic       aresetn;
  logic       start_a, start_b;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [7:0] wr_a, rd_a, err_a, wr_b, rd_b, err_b;
`ifdef SELFTEST_ERR_INJECT_EN
  logic       inject_err = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_selftest_mem_system dut (
    .aclk(clk), .aresetn(aresetn), .start(start_a),
`ifdef SELFTEST_ERR_INJECT_EN
    .inject_err(inject_err),
`endif
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .wr_count(wr_a), .rd_count(rd_a), .err_count(err_a)
  );

  axi_selftest_mem_system #(.BASE_ADDR(1000), .NUM_TXN(8)) dut_oor (
    .aclk(clk), .aresetn(aresetn), .start(start_b),
`ifdef SELFTEST_ERR_INJECT_EN
    .inject_err(1'b0),
`endif
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .wr_count(wr_b), .rd_count(rd_b), .err_count(err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pattern word i is the seed XOR the byte i copied into all four lanes.
  function automatic logic [31:0] model_data(input int i);
    return 32'hDEAD_BEEF ^ (32'(i) * 32'h0101_0101);
  endfunction

  // Out-of-range txns fail on both write and read; an injected txn fails once on read.
  function automatic int model_err(input int base, input int n, input bit inj);
    int e = 0;
    for (int i = 0; i < n; i++) begin
      if (base + 4*i >= 4*MEM_WORDS) e += 2;
      else if (inj && i == 0)        e += 1;
    end
    return e;
  endfunction

  // Pulses start on the chosen instance, optionally pulses it again mid-run,
  // then waits for done within the allowed budget.
  task automatic run(input bit which, input int budget, input int extra_at, output int cyc);
    cyc = 0;
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    check("busy_after_start", which ? busy_b : busy_a, 1);
    check("done_cleared", which ? done_b : done_a, 0);
    while (!(which ? done_b : done_a) && cyc <= budget) begin
      if (cyc == extra_at) begin
        if (which) start_b = 1'b1; else start_a = 1'b1;
      end
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      cyc++;
    end
    check("done_in_budget", 32'(cyc <= budget), 1);
  endtask

  initial begin
    int cyc, k, wait_cyc;
    aresetn = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_outputs", {busy_a, done_a, pass_a, wr_a, rd_a, err_a}, 0);
    aresetn = 1'b1;
    @(negedge clk);
    check("post_rst_outputs", {busy_a, done_a, pass_a, wr_a, rd_a, err_a}, 0);
    check("post_rst_valids", {dut.w_bus.awvalid, dut.w_bus.wvalid, dut.w_bus.arvalid,
                              dut.w_bus.bvalid, dut.w_bus.rvalid}, 0);
    repeat ($urandom_range(0, 4)) @(negedge clk);

    // Full run with a spurious start pulse while busy.
    run(1'b0, 4*16 + 3, int'($urandom_range(3, 40)), cyc);
    check("busy_after_done", busy_a, 0);
    check("wr_count", wr_a, 16);
    check("rd_count", rd_a, 16);
    check("err_count", err_a, model_err(0, 16, 1'b0));
    check("pass", pass_a, 1);
    check("mem_word1_const", dut.u_slave.r_mem[1], 32'hDFAC_BFEE);
    for (int j = 0; j < 3; j++) begin
      k = int'($urandom_range(0, 15));
      check("mem_word_rand", dut.u_slave.r_mem[k], model_data(k));
    end

    // Range that crosses the top of memory.
    run(1'b1, 4*8 + 3, -1, cyc);
    check("oor_wr_count", wr_b, 8);
    check("oor_rd_count", rd_b, 8);
    check("oor_err_count", err_b, model_err(1000, 8, 1'b0));
    check("oor_pass", pass_b, 0);
    check("oor_mem_in_range", dut_oor.u_slave.r_mem[255], model_data(5));

    // Abort after the 5th write response, then rerun from scratch.
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_cyc = 0;
    while (wr_a != 8'd5 && wait_cyc < 40) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("abort_reached_wr5", wr_a, 5);
    repeat ($urandom_range(0, 1)) @(negedge clk);
    aresetn = 1'b0;
    #1;
    check("abort_outputs", {busy_a, done_a, pass_a, wr_a, rd_a, err_a}, 0);
    check("abort_valids", {dut.w_bus.awvalid, dut.w_bus.wvalid, dut.w_bus.arvalid,
                           dut.w_bus.bvalid, dut.w_bus.rvalid}, 0);
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    run(1'b0, 4*16 + 3, -1, cyc);
    check("rerun_wr_count", wr_a, 16);
    check("rerun_rd_count", rd_a, 16);
    check("rerun_err_count", err_a, 0);
    check("rerun_pass", pass_a, 1);

`ifdef SELFTEST_ERR_INJECT_EN
    inject_err = 1'b1;
    run(1'b0, 4*16 + 3, -1, cyc);
    inject_err = 1'b0;
    check("inj_mem_word0", dut.u_slave.r_mem[0], 32'hDEAD_BEEE);
    check("inj_err_count", err_a, model_err(0, 16, 1'b1));
    check("inj_pass", pass_a, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
